// File: rtl/rom_arb_pkg.sv
// Bus widths, reset level and owner encoding shared by the instruction-ROM arbiter.
// Owner codes are stored in the arbiter state register; IDLE must stay the all-zero code.
package rom_arb_pkg;
   localparam int   MemAddrBus = 32;
   localparam int   MemBus     = 32;
   localparam logic RstEnable  = 1'b0;

   typedef enum logic [1:0] {
      RomArbIdle = 2'd0,
      RomArbM0   = 2'd1,
      RomArbM1   = 2'd2
   } owner_e;
endpackage

// File: rtl/rom_arb_sel.sv
// Grant and next-owner selection for the two-master ROM arbiter. Purely combinational:
// bounded-burst round-robin, loader wins a tie from IDLE.
module rom_arb_sel
   import rom_arb_pkg::*;
#(
   parameter int BURST_MAX = 8,
   parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
   input  owner_e           owner_i,
   input  logic [CNT_W-1:0] burst_cnt_i,
   input  logic             m0_req_i,
   input  logic             m1_req_i,
   output logic             m0_gnt_o,
   output logic             m1_gnt_o,
   output owner_e           owner_d_o
);
   localparam logic [CNT_W-1:0] BurstMax = CNT_W'(BURST_MAX);

   always_comb begin
      m0_gnt_o = 1'b0;
      m1_gnt_o = 1'b0;
      case (owner_i)
         RomArbM0: begin
            if (m0_req_i && (!m1_req_i || burst_cnt_i < BurstMax)) m0_gnt_o = 1'b1;
            else if (m1_req_i)                                     m1_gnt_o = 1'b1;
         end
         RomArbM1: begin
            if (m1_req_i && (!m0_req_i || burst_cnt_i < BurstMax)) m1_gnt_o = 1'b1;
            else if (m0_req_i)                                     m0_gnt_o = 1'b1;
         end
         default: begin
            if (m1_req_i)      m1_gnt_o = 1'b1;
            else if (m0_req_i) m0_gnt_o = 1'b1;
         end
      endcase
   end

   always_comb begin
      owner_d_o = RomArbIdle;
      if (m1_gnt_o)      owner_d_o = RomArbM1;
      else if (m0_gnt_o) owner_d_o = RomArbM0;
   end
endmodule

// File: rtl/rom_arb.sv
// Shares the single-port instruction ROM between core fetch (m0) and loader (m1).
// Combinational grant, one-cycle registered response; a master stalls simply by not being granted.
module rom_arb
   import rom_arb_pkg::*;
#(
   parameter int BURST_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_i,
   input  logic [MemAddrBus-1:0] m0_addr_i,
   output logic                  m0_gnt_o,
   output logic                  m0_ack_o,
   output logic [MemBus-1:0]     m0_data_o,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [MemAddrBus-1:0] m1_addr_i,
   input  logic [MemBus-1:0]     m1_data_i,
   output logic                  m1_gnt_o,
   output logic                  m1_ack_o,
   output logic [MemBus-1:0]     m1_data_o,
   output logic                  rom_req_o,
   output logic                  rom_we_o,
   output logic [MemAddrBus-1:0] rom_addr_o,
   output logic [MemBus-1:0]     rom_data_o,
   input  logic [MemBus-1:0]     rom_data_i,
   output logic                  hold_flag_o
);
   localparam int              CntW     = $clog2(BURST_MAX + 1);
   localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

   owner_e            owner_q, owner_d, sel_owner;
   logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
   logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
   logic [MemBus-1:0] m0_data_q, m0_data_d, m1_data_q, m1_data_d;
   logic              run, sel_gnt0, sel_gnt1, m0_gnt, m1_gnt;

   rom_arb_sel #(.BURST_MAX(BURST_MAX), .CNT_W(CntW)) u_sel (
      .owner_i     (owner_q),
      .burst_cnt_i (burst_cnt_q),
      .m0_req_i    (m0_req_i),
      .m1_req_i    (m1_req_i),
      .m0_gnt_o    (sel_gnt0),
      .m1_gnt_o    (sel_gnt1),
      .owner_d_o   (sel_owner)
   );

   // Grants are masked during reset so nothing reaches the ROM or the response registers.
   assign run    = (rst != RstEnable);
   assign m0_gnt = sel_gnt0 & run;
   assign m1_gnt = sel_gnt1 & run;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         owner_q     <= RomArbIdle;
         burst_cnt_q <= '0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_data_q   <= '0;
         m1_data_q   <= '0;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         m0_ack_q    <= m0_ack_d;
         m1_ack_q    <= m1_ack_d;
         m0_data_q   <= m0_data_d;
         m1_data_q   <= m1_data_d;
      end
   end

   always_comb begin
      owner_d     = run ? sel_owner : RomArbIdle;
      burst_cnt_d = '0;
      if (owner_d != RomArbIdle) begin
         if (owner_d != owner_q)         burst_cnt_d = CntW'(1);
         else if (burst_cnt_q != BurstMax) burst_cnt_d = burst_cnt_q + 1'b1;
         else                            burst_cnt_d = burst_cnt_q;
      end
      m0_ack_d  = m0_gnt;
      m1_ack_d  = m1_gnt;
      m0_data_d = m0_gnt ? rom_data_i : '0;
      m1_data_d = (m1_gnt && !m1_we_i) ? rom_data_i : '0;
   end

   always_comb begin
      rom_req_o  = m0_gnt | m1_gnt;
      rom_we_o   = m1_gnt & m1_we_i;
      rom_addr_o = '0;
      rom_data_o = '0;
      if (m0_gnt) begin
         rom_addr_o = m0_addr_i;
      end else if (m1_gnt) begin
         rom_addr_o = m1_addr_i;
         rom_data_o = m1_data_i;
      end
   end

   assign m0_gnt_o    = m0_gnt;
   assign m1_gnt_o    = m1_gnt;
   assign m0_ack_o    = m0_ack_q;
   assign m1_ack_o    = m1_ack_q;
   assign m0_data_o   = m0_data_q;
   assign m1_data_o   = m1_data_q;
   assign hold_flag_o = run & m0_req_i & ~m0_gnt;
endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb with a behavioural ROM, a directed vector table, a fairness run and random traffic.
module tb_rom_arb;
   localparam int B = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_gnt, m0_ack, m1_req, m1_we, m1_gnt, m1_ack;
   logic        rom_req, rom_we, hold;
   logic [31:0] m0_addr, m0_rdat, m1_addr, m1_wdat, m1_rdat;
   logic [31:0] rom_addr, rom_wdat, rom_rdat;

   logic [31:0] rom_mem [64];
   logic [31:0] ref_mem [64];
   int          tests = 0;
   int          fails = 0;
   int          mown   = 0;   // 0 none, 1 core, 2 loader
   int          streak = 0;   // consecutive grants held by mown

   always #5 clk = ~clk;

   rom_arb #(.BURST_MAX(B)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack), .m0_data_o(m0_rdat),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
      .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack), .m1_data_o(m1_rdat),
      .rom_req_o(rom_req), .rom_we_o(rom_we), .rom_addr_o(rom_addr), .rom_data_o(rom_wdat),
      .rom_data_i(rom_rdat), .hold_flag_o(hold)
   );

   assign rom_rdat = rom_mem[rom_addr[7:2]];
   always @(posedge clk) if (rom_req && rom_we) rom_mem[rom_addr[7:2]] <= rom_wdat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One bus cycle: drive, check combinational outputs, advance, check the response.
   task automatic step(input logic r, input logic q0, input logic [31:0] a0,
                       input logic q1, input logic we, input logic [31:0] a1, input logic [31:0] d1,
                       output logic g0o, output logic g1o, output logic ho);
      logic g0, g1, ea0, ea1;
      logic [31:0] ed0, ed1, eaddr;
      int nown;
      rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_we = we; m1_addr = a1; m1_wdat = d1;
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (r) begin
         case (mown)
            1: if (q0 && (!q1 || streak < B)) g0 = 1'b1; else if (q1) g1 = 1'b1;
            2: if (q1 && (!q0 || streak < B)) g1 = 1'b1; else if (q0) g0 = 1'b1;
            default: if (q1) g1 = 1'b1; else if (q0) g0 = 1'b1;
         endcase
      end
      eaddr = g0 ? a0 : (g1 ? a1 : 32'h0);
      chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, g0});
      chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, g1});
      chk("rom_req", {31'h0, rom_req}, {31'h0, g0 | g1});
      chk("rom_we", {31'h0, rom_we}, {31'h0, g1 & we});
      chk("rom_addr", rom_addr, eaddr);
      chk("rom_wdata", rom_wdat, g1 ? d1 : 32'h0);
      chk("hold_flag", {31'h0, hold}, {31'h0, r & q0 & ~g0});
      g0o = m0_gnt; g1o = m1_gnt; ho = hold;
      ea0 = g0; ea1 = g1;
      ed0 = g0 ? ref_mem[a0[7:2]] : 32'h0;
      ed1 = (g1 && !we) ? ref_mem[a1[7:2]] : 32'h0;
      if (g1 && we) ref_mem[a1[7:2]] = d1;
      nown   = g0 ? 1 : (g1 ? 2 : 0);
      streak = (nown == 0) ? 0 : ((nown == mown) ? streak + 1 : 1);
      mown   = nown;
      @(negedge clk);
      chk("m0_ack", {31'h0, m0_ack}, {31'h0, ea0});
      chk("m0_data", m0_rdat, ed0);
      chk("m1_ack", {31'h0, m1_ack}, {31'h0, ea1});
      chk("m1_data", m1_rdat, ed1);
   endtask

   typedef struct {
      logic r, q0; logic [31:0] a0; logic q1, we; logic [31:0] a1, d1;
      logic eg0, eg1, eh, ea0, ea1; logic [31:0] ed0, ed1;
   } vec_t;

   function automatic vec_t mk(logic r, logic q0, logic [31:0] a0, logic q1, logic we,
                               logic [31:0] a1, logic [31:0] d1, logic eg0, logic eg1, logic eh,
                               logic ea0, logic ea1, logic [31:0] ed0, logic [31:0] ed1);
      vec_t v;
      v.r = r; v.q0 = q0; v.a0 = a0; v.q1 = q1; v.we = we; v.a1 = a1; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.eh = eh; v.ea0 = ea0; v.ea1 = ea1; v.ed0 = ed0; v.ed1 = ed1;
      return v;
   endfunction

   initial begin
      vec_t vt [18];
      logic g0, g1, h, r, q0, q1, we;

      for (int i = 0; i < 64; i++) begin
         rom_mem[i] = 32'hA500_0000 | 32'(i);
         ref_mem[i] = 32'hA500_0000 | 32'(i);
      end
      rom_mem[4] = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;

      //            r   q0  a0     q1  we  a1     d1            g0  g1  h   ak0 ak1 d0            d1
      vt[0]  = mk(0, 1, 32'h00, 1, 0, 32'h00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
      vt[1]  = mk(0, 1, 32'h00, 1, 0, 32'h00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
      vt[2]  = mk(1, 1, 32'h10, 1, 0, 32'h04, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'hA5000001);
      vt[3]  = mk(1, 1, 32'h10, 0, 0, 32'h00, 32'h0,        1, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
      vt[4]  = mk(1, 0, 32'h00, 1, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 1, 32'h0,        32'h0);
      vt[5]  = mk(1, 1, 32'h20, 0, 0, 32'h00, 32'h0,        1, 0, 0, 1, 0, 32'h12345678, 32'h0);
      vt[6]  = mk(1, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
      vt[7]  = mk(1, 1, 32'h00, 0, 0, 32'h00, 32'h0,        1, 0, 0, 1, 0, 32'hA5000000, 32'h0);
      vt[8]  = mk(1, 1, 32'h04, 0, 0, 32'h00, 32'h0,        1, 0, 0, 1, 0, 32'hA5000001, 32'h0);
      vt[9]  = mk(1, 0, 32'h00, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 1, 32'h0,        32'hA5000002);
      vt[10] = mk(1, 1, 32'h00, 1, 0, 32'h08, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'hA5000002);
      vt[11] = mk(1, 1, 32'h00, 1, 0, 32'h08, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'hA5000002);
      vt[12] = mk(1, 1, 32'h00, 1, 0, 32'h08, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'hA5000002);
      vt[13] = mk(1, 1, 32'h00, 1, 0, 32'h08, 32'h0,        1, 0, 0, 1, 0, 32'hA5000000, 32'h0);
      vt[14] = mk(1, 1, 32'h00, 0, 0, 32'h00, 32'h0,        1, 0, 0, 1, 0, 32'hA5000000, 32'h0);
      vt[15] = mk(0, 1, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
      vt[16] = mk(1, 1, 32'h00, 1, 0, 32'h08, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'hA5000002);
      vt[17] = mk(1, 0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);

      @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         step(vt[i].r, vt[i].q0, vt[i].a0, vt[i].q1, vt[i].we, vt[i].a1, vt[i].d1, g0, g1, h);
         chk($sformatf("vec%0d_m0_gnt", i), {31'h0, g0}, {31'h0, vt[i].eg0});
         chk($sformatf("vec%0d_m1_gnt", i), {31'h0, g1}, {31'h0, vt[i].eg1});
         chk($sformatf("vec%0d_hold", i), {31'h0, h}, {31'h0, vt[i].eh});
         chk($sformatf("vec%0d_m0_ack", i), {31'h0, m0_ack}, {31'h0, vt[i].ea0});
         chk($sformatf("vec%0d_m1_ack", i), {31'h0, m1_ack}, {31'h0, vt[i].ea1});
         chk($sformatf("vec%0d_m0_data", i), m0_rdat, vt[i].ed0);
         chk($sformatf("vec%0d_m1_data", i), m1_rdat, vt[i].ed1);
      end

      // Both masters requesting from IDLE: loader bursts first, then strict B/B alternation.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 32'h10, 32'h0, g0, g1, h);
         chk($sformatf("fair%0d_m1_gnt", i), {31'h0, g1}, {31'h0, (i % (2 * B)) < B});
         chk($sformatf("fair%0d_hold", i), {31'h0, h}, {31'h0, (i % (2 * B)) < B});
      end

      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 49) != 0);
         q0 = ($urandom_range(0, 3) != 0);
         q1 = ($urandom_range(0, 3) != 0);
         we = $urandom_range(0, 1) == 1;
         step(r, q0, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
              q1, we, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, g0, g1, h);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
